// File: rtl/debug_line_arbiter.sv
// Round-robin arbiter that shares one UART line writer among several debug-string sources.
// Captures per-source send pulses, issues one send strobe per granted line and tracks the writer handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no line in flight; grant next pending source when writer idle
// ISSUE     | granted line registered; send strobe raised at the next edge
// WAIT_BUSY | waiting for writer ready to fall, bounded by the timeout
// WAIT_DONE | writer busy with the line; wait for ready to return
module debug_line_arbiter #(
    parameter  int NUM_REQ      = 2,
    parameter  int LINE_BITS    = 640,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int GID_W        = $clog2(NUM_REQ),
    localparam int CNT_W        = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*LINE_BITS-1:0] req_line,
    input  logic [NUM_REQ-1:0]           req_send,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [LINE_BITS-1:0]         line,
    output logic                         send,
    input  logic                         ready,
    output logic [GID_W-1:0]             grant_id,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [7:0]                   drop_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pend_clr;
    logic [GID_W-1:0]   last_grant;
    logic [GID_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               grant_go;
    logic               tmo_hit;
    logic               line_done;
    logic               drop_hit;

    // Walk last_grant+NUM_REQ down to last_grant+1 so the nearest pending source wins.
    always_comb begin
        int         idx;
        logic [GID_W-1:0] cand;
        sel_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GID_W'(idx);
            if (pending[cand]) sel_idx = cand;
        end
    end

    assign grant_go  = (state == IDLE) && (|pending) && ready;
    assign tmo_hit   = (state == WAIT_BUSY) && ready && (tmo_cnt == CNT_W'(0));
    assign line_done = ((state == WAIT_DONE) && ready) || tmo_hit;
    assign drop_hit  = |(req_send & pending);

    always_comb begin
        pend_clr = '0;
        if (line_done) pend_clr[grant_id] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_go) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!ready)       state_nxt = WAIT_DONE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            WAIT_DONE: if (ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state != IDLE);
        req_ready = ~pending;
    end

    // Send is registered so the writer sees it in the first WAIT_BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line       <= '0;
            send       <= 1'b0;
            grant_id   <= '0;
            last_grant <= GID_W'(NUM_REQ - 1);
        end else begin
            send <= (state == ISSUE);
            if (grant_go) begin
                line       <= req_line[int'(sel_idx)*LINE_BITS +: LINE_BITS];
                grant_id   <= sel_idx;
                last_grant <= sel_idx;
            end
        end
    end

    // Timeout is a down-counter loaded on issue; terminal count with ready still high abandons the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                tmo_cnt <= CNT_W'(BUSY_TIMEOUT - 1);
            else if ((state == WAIT_BUSY) && ready && !tmo_hit)
                tmo_cnt <= tmo_cnt - CNT_W'(1);
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            drop_count <= '0;
        end else begin
            pending <= (pending | req_send) & ~pend_clr;
            if (drop_hit && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule
